if_fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the program counter and fetches from instruction memory over a req/ack handshake.

---
 rtl/imem_if.sv | 17 +
 rtl/if_fetch_stage.sv | 155 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_if.sv
// ----------------------------------------------------------------------------
// imem_if
// Request/acknowledge bus between the fetch stage and instruction memory.
//   req    master -> slave  fetch request, held until ack
//   addr   master -> slave  word-aligned fetch address, stable while req && !ack
//   ack    slave  -> master rdata valid this cycle, completes the request
//   rdata  slave  -> master instruction word
// ----------------------------------------------------------------------------
interface imem_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage. Owns the program counter, fetches over a req/ack
// memory bus and feeds the IF stage register. Variable memory latency is
// absorbed by emitting bubbles (PC=0, Instruction=0). A branch redirect that
// arrives while a request is outstanding is remembered and applied once the
// in-flight word has been acknowledged and thrown away.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   freeze             hazard stall shared with the IF stage register
//   Branch_taken       redirect / flush shared with the IF stage register
//   Branch_Address     redirect target, bits [1:0] forced to 00
//   imem               instruction memory bus (master side)
//   PC                 fetched address + 4, or 0 for a bubble
//   Instruction        fetched word, or 0 for a bubble
//   Instruction_valid  PC/Instruction carry a real fetch
// ----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_Address,
    imem_if.master      imem,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic        Instruction_valid
);

    // FETCH: request in flight for pc_q.
    // KILL : request in flight whose data must be dropped (redirect pending).
    // HOLD : a fetched word is parked in buf_q while the pipeline is frozen.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_KILL  = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] tgt_q,   tgt_d;
    logic [31:0] buf_q,   buf_d;

    logic [31:0] br_tgt;
    logic [31:0] pc_plus4;
    logic        req_active;
    logic        ack_eff;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        valid_out;

    assign br_tgt     = Branch_Address & 32'hFFFF_FFFC;
    assign pc_plus4   = pc_q + 32'd4;   // wraps modulo 2^32
    assign req_active = (state_q == ST_FETCH) || (state_q == ST_KILL);
    // An ack is only meaningful while our request is up.
    assign ack_eff    = imem.ack && req_active;

    assign imem.req   = req_active && !rst;
    assign imem.addr  = pc_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        buf_d     = buf_q;
        pc_out    = 32'd0;
        instr_out = 32'd0;
        valid_out = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (ack_eff) begin
                    if (Branch_taken) begin
                        // Word arrived but is already flushed; refetch at target.
                        pc_d = br_tgt;
                    end else begin
                        pc_out    = pc_plus4;
                        instr_out = imem.rdata;
                        valid_out = 1'b1;
                        if (freeze) begin
                            // The IF register keeps this word; park a copy so
                            // we can keep presenting it without refetching.
                            buf_d   = imem.rdata;
                            state_d = ST_HOLD;
                        end else begin
                            pc_d = pc_plus4;
                        end
                    end
                end else if (Branch_taken) begin
                    // Address must stay stable until ack, so defer the redirect.
                    tgt_d   = br_tgt;
                    state_d = ST_KILL;
                end
            end

            ST_KILL: begin
                if (Branch_taken) begin
                    tgt_d = br_tgt;
                end
                if (ack_eff) begin
                    pc_d    = Branch_taken ? br_tgt : tgt_q;
                    state_d = ST_FETCH;
                end
            end

            ST_HOLD: begin
                if (Branch_taken) begin
                    pc_d    = br_tgt;
                    state_d = ST_FETCH;
                end else begin
                    pc_out    = pc_plus4;
                    instr_out = buf_q;
                    valid_out = 1'b1;
                    if (!freeze) begin
                        pc_d    = pc_plus4;
                        state_d = ST_FETCH;
                    end
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            tgt_q   <= 32'd0;
            buf_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            buf_q   <= buf_d;
        end
    end

    // Outputs read as a bubble for as long as reset is asserted.
    always_comb begin
        PC                = rst ? 32'd0 : pc_out;
        Instruction       = rst ? 32'd0 : instr_out;
        Instruction_valid = !rst && valid_out;
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_stage
// Drives the fetch stage against a memory with programmable latency whose
// word at address a is (a/4)+1. A reference model tracks only the address of
// the next instruction the pipeline should receive: every delivered word must
// be the one at that address; it advances when a word is taken (valid, no
// freeze) and jumps to the target on a branch. A second instance checks the
// PC wrap from RESET_PC = 32'hFFFF_FFFC.
// ----------------------------------------------------------------------------
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        br = 1'b0;
    logic [31:0] ba = 32'd0;
    logic [31:0] pc_o, instr_o;
    logic        valid_o;

    logic [31:0] pc2_o, instr2_o;
    logic        valid2_o;

    int unsigned lat = 0;
    logic        stray_ack = 1'b0;
    int unsigned wait_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    bit          mon_en = 1'b0;
    logic [31:0] exp_pc = 32'd0;
    bit          prev_pending = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    int          deliveries = 0;

    imem_if bus ();
    imem_if bus2 ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'd1;
    endfunction

    always #5 clk = ~clk;

    // Memory with `lat` wait cycles; acks seen while req=0 carry junk data.
    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 0;
        else if (bus.req && !bus.ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end
    assign bus.ack   = bus.req ? (wait_cnt >= lat) : stray_ack;
    assign bus.rdata = bus.req ? mem_word(bus.addr) : 32'hDEAD_BEEF;

    assign bus2.ack   = bus2.req;
    assign bus2.rdata = mem_word(bus2.addr);

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .rst               (rst),
        .freeze            (freeze),
        .Branch_taken      (br),
        .Branch_Address    (ba),
        .imem              (bus),
        .PC                (pc_o),
        .Instruction       (instr_o),
        .Instruction_valid (valid_o)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk               (clk),
        .rst               (rst),
        .freeze            (1'b0),
        .Branch_taken      (1'b0),
        .Branch_Address    (32'd0),
        .imem              (bus2),
        .PC                (pc2_o),
        .Instruction       (instr2_o),
        .Instruction_valid (valid2_o)
    );

    // Reference model: checks every cycle of dut once enabled.
    always @(negedge clk) begin
        if (rst) begin
            exp_pc       = 32'd0;
            prev_pending = 1'b0;
        end else if (mon_en) begin
            tests_run++;
            if (br) begin
                if (valid_o !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL mon_branch_bubble t=%0t: valid=%b required 0", $time, valid_o);
                end
            end else if (valid_o === 1'b1) begin
                if (instr_o !== mem_word(exp_pc) || pc_o !== exp_pc + 32'd4) begin
                    tests_failed++;
                    $display("FAIL mon_delivery t=%0t: PC=%h Instr=%h required PC=%h Instr=%h",
                             $time, pc_o, instr_o, exp_pc + 32'd4, mem_word(exp_pc));
                end
            end else if (pc_o !== 32'd0 || instr_o !== 32'd0 || valid_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL mon_bubble t=%0t: PC=%h Instr=%h valid=%b required zeros",
                         $time, pc_o, instr_o, valid_o);
            end
            if (prev_pending) begin
                tests_run++;
                if (bus.req !== 1'b1 || bus.addr !== prev_addr) begin
                    tests_failed++;
                    $display("FAIL mon_req_hold t=%0t: req=%b addr=%h required req=1 addr=%h",
                             $time, bus.req, bus.addr, prev_addr);
                end
            end
            if (br) exp_pc = ba & 32'hFFFF_FFFC;
            else if (valid_o === 1'b1 && !freeze) begin
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
            prev_pending = bus.req && !bus.ack;
            prev_addr    = bus.addr;
        end
    end

    task automatic do_reset();
        rst = 1'b1; freeze = 1'b0; br = 1'b0; ba = 32'd0; stray_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        lat = 0; stray_ack = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.req !== 1'b0 || bus2.req !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_req: req=%b req2=%b required 0", bus.req, bus2.req);
        end
        tests_run++;
        if (pc_o !== 32'd0 || instr_o !== 32'd0 || valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: PC=%h Instr=%h valid=%b required zeros", pc_o, instr_o, valid_o);
        end
        do_reset();
    endtask

    task automatic test_zero_wait();
        do_reset();
        lat = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.addr !== 32'(4 * i) || pc_o !== 32'(4 * i + 4) ||
                instr_o !== 32'(i + 1) || valid_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL zero_wait[%0d]: addr=%h PC=%h Instr=%h valid=%b required %h %h %h 1",
                         i, bus.addr, pc_o, instr_o, valid_o, 4 * i, 4 * i + 4, i + 1);
            end
            next_cycle();
        end
    endtask

    task automatic test_latency();
        lat = 3;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if (c < 3) begin
                if (bus.req !== 1'b1 || bus.addr !== 32'd0 || valid_o !== 1'b0 ||
                    pc_o !== 32'd0 || instr_o !== 32'd0) begin
                    tests_failed++;
                    $display("FAIL latency_wait[%0d]: req=%b addr=%h valid=%b PC=%h Instr=%h required 1 0 0 0 0",
                             c, bus.req, bus.addr, valid_o, pc_o, instr_o);
                end
            end else if (c == 3) begin
                if (valid_o !== 1'b1 || pc_o !== 32'd4 || instr_o !== 32'd1) begin
                    tests_failed++;
                    $display("FAIL latency_ack: valid=%b PC=%h Instr=%h required 1 4 1", valid_o, pc_o, instr_o);
                end
            end else if (bus.req !== 1'b1 || bus.addr !== 32'd4) begin
                tests_failed++;
                $display("FAIL latency_next: req=%b addr=%h required 1 4", bus.req, bus.addr);
            end
            next_cycle();
        end
    endtask

    task automatic test_freeze();
        lat = 0;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            freeze    = (c >= 2 && c <= 6);
            stray_ack = (c >= 3 && c <= 6);
            @(negedge clk);
            tests_run++;
            if (c == 2) begin
                if (bus.addr !== 32'd8 || valid_o !== 1'b1 || instr_o !== 32'd3 || pc_o !== 32'd12) begin
                    tests_failed++;
                    $display("FAIL freeze_ack: addr=%h valid=%b Instr=%h PC=%h required 8 1 3 c",
                             bus.addr, valid_o, instr_o, pc_o);
                end
            end else if (c >= 3 && c <= 7) begin
                if (bus.req !== 1'b0 || valid_o !== 1'b1 || instr_o !== 32'd3 || pc_o !== 32'd12) begin
                    tests_failed++;
                    $display("FAIL freeze_hold[%0d]: req=%b valid=%b Instr=%h PC=%h required 0 1 3 c",
                             c, bus.req, valid_o, instr_o, pc_o);
                end
            end else if (c == 8) begin
                if (bus.req !== 1'b1 || bus.addr !== 32'd12 || instr_o !== 32'd4) begin
                    tests_failed++;
                    $display("FAIL freeze_release: req=%b addr=%h Instr=%h required 1 c 4",
                             bus.req, bus.addr, instr_o);
                end
            end else if (valid_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL freeze_pre[%0d]: valid=%b required 1", c, valid_o);
            end
            next_cycle();
        end
        freeze = 1'b0; stray_ack = 1'b0;
    endtask

    task automatic test_branch_wait();
        lat = 4;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            br = (c == 1);
            ba = 32'h43;
            @(negedge clk);
            tests_run++;
            if (c <= 4) begin
                if (bus.req !== 1'b1 || bus.addr !== 32'd0 || valid_o !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL branch_wait[%0d]: req=%b addr=%h valid=%b required 1 0 0",
                             c, bus.req, bus.addr, valid_o);
                end
            end else if (c < 9) begin
                if (bus.req !== 1'b1 || bus.addr !== 32'h40) begin
                    tests_failed++;
                    $display("FAIL branch_target[%0d]: req=%b addr=%h required 1 40", c, bus.req, bus.addr);
                end
            end else if (valid_o !== 1'b1 || instr_o !== 32'h11 || pc_o !== 32'h44) begin
                tests_failed++;
                $display("FAIL branch_first: valid=%b Instr=%h PC=%h required 1 11 44", valid_o, instr_o, pc_o);
            end
            next_cycle();
        end
        br = 1'b0;
    endtask

    task automatic test_branch_ack_hold();
        lat = 0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            br     = (c == 1 || c == 3);
            ba     = (c == 1) ? 32'h80 : 32'h102;
            freeze = (c == 2 || c == 3);
            @(negedge clk);
            tests_run++;
            case (c)
                1: if (valid_o !== 1'b0 || bus.addr !== 32'd4) begin
                    tests_failed++;
                    $display("FAIL br_on_ack: valid=%b addr=%h required 0 4", valid_o, bus.addr);
                end
                2: if (bus.addr !== 32'h80 || instr_o !== 32'h21 || pc_o !== 32'h84 || valid_o !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL br_target_fetch: addr=%h Instr=%h PC=%h valid=%b required 80 21 84 1",
                             bus.addr, instr_o, pc_o, valid_o);
                end
                3: if (valid_o !== 1'b0 || bus.req !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL br_in_hold: valid=%b req=%b required 0 0", valid_o, bus.req);
                end
                4: if (bus.addr !== 32'h100 || instr_o !== 32'h41 || pc_o !== 32'h104) begin
                    tests_failed++;
                    $display("FAIL br_after_hold: addr=%h Instr=%h PC=%h required 100 41 104",
                             bus.addr, instr_o, pc_o);
                end
                default: if (instr_o !== 32'd1) begin
                    tests_failed++;
                    $display("FAIL br_pre: Instr=%h required 1", instr_o);
                end
            endcase
            next_cycle();
        end
        br = 1'b0; freeze = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        tests_run++;
        if (bus2.addr !== 32'hFFFF_FFFC || pc2_o !== 32'd0 || valid2_o !== 1'b1 || instr2_o !== 32'h4000_0000) begin
            tests_failed++;
            $display("FAIL wrap_first: addr=%h PC=%h valid=%b Instr=%h required fffffffc 0 1 40000000",
                     bus2.addr, pc2_o, valid2_o, instr2_o);
        end
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (bus2.addr !== 32'd0 || pc2_o !== 32'd4) begin
            tests_failed++;
            $display("FAIL wrap_second: addr=%h PC=%h required 0 4", bus2.addr, pc2_o);
        end
        next_cycle();
    endtask

    task automatic test_async_reset();
        lat = 0;
        do_reset();
        next_cycle();
        next_cycle();
        lat = 3;          // request at addr 8 now waits
        next_cycle();
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (bus.req !== 1'b0 || valid_o !== 1'b0 || pc_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL async_rst_drop: req=%b valid=%b PC=%h required 0 0 0", bus.req, valid_o, pc_o);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.req !== 1'b1 || bus.addr !== 32'd0 || valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_rst_restart: req=%b addr=%h valid=%b required 1 0 0",
                     bus.req, bus.addr, valid_o);
        end
        next_cycle();
    endtask

    task automatic test_random();
        int start;
        do_reset();
        start = deliveries;
        for (int c = 0; c < 800; c++) begin
            freeze    = ($urandom_range(0, 3) == 0);
            br        = ($urandom_range(0, 9) == 0);
            ba        = 32'($urandom_range(0, 1023));
            stray_ack = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 15) == 0) lat = $urandom_range(0, 3);
            next_cycle();
        end
        br = 1'b0; freeze = 1'b0; stray_ack = 1'b0;
        tests_run++;
        if (deliveries - start < 40) begin
            tests_failed++;
            $display("FAIL random_progress: deliveries=%0d required at least 40", deliveries - start);
        end
    endtask

    initial begin
        #1;
        test_reset();
        mon_en = 1'b1;
        test_zero_wait();
        test_latency();
        test_freeze();
        test_branch_wait();
        test_branch_ack_hold();
        test_wrap();
        test_async_reset();
        test_random();
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
